// File: rtl/sc_micro_sequencer.sv
// Next-address generator for the microcoded control unit: selects the control-store address
// from Cond/JumpAddr/PSR/IR. Wait-state support is built only when SC_SEQ_WAITSTATE_EN is defined.
module sc_micro_sequencer #(
  parameter int                         SEQ_ADDRWIDTH = 11,
  parameter logic [SEQ_ADDRWIDTH-1:0]   SEQ_RESETADDR = '0
) (
  input  logic                     SC_SEQ_CLOCK_50,
  input  logic                     SC_SEQ_RESET_InLow,
  input  logic [2:0]               SC_SEQ_Cond_InBUS,
  input  logic [SEQ_ADDRWIDTH-1:0] SC_SEQ_JumpAddr_InBUS,
  input  logic                     SC_SEQ_Read_In,
  input  logic                     SC_SEQ_Write_In,
  input  logic [3:0]               SC_SEQ_PSR_InBUS,
  input  logic [31:0]              SC_SEQ_IR_InBUS,
  input  logic                     SC_SEQ_MemReady_In,
  output logic [SEQ_ADDRWIDTH-1:0] SC_SEQ_CSAddr_OutBUS,
  output logic                     SC_SEQ_MIRLoad_Out,
  output logic                     SC_SEQ_Stall_Out
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_WAIT} state_t;

  state_t                   r_state;
  logic [SEQ_ADDRWIDTH-1:0] r_csaddr;
  logic                     r_mirload;
  logic                     r_stall;

  logic                     w_taken;
  logic [SEQ_ADDRWIDTH-1:0] w_incr;
  logic [SEQ_ADDRWIDTH-1:0] w_decode;
  logic [SEQ_ADDRWIDTH-1:0] w_next;
  logic                     w_pending;
  logic                     w_ready;
  logic                     w_unused;

  // Increment wraps naturally at 2^SEQ_ADDRWIDTH.
  assign w_incr   = r_csaddr + 1'b1;
  assign w_decode = SEQ_ADDRWIDTH'({1'b1, SC_SEQ_IR_InBUS[31:30], SC_SEQ_IR_InBUS[24:19], 2'b00});

  always_comb begin
    // NOTE: default first so every path assigns w_taken; otherwise a latch is inferred.
    w_taken = 1'b0;
    unique case (SC_SEQ_Cond_InBUS)
      3'b001:  w_taken = SC_SEQ_PSR_InBUS[3];
      3'b010:  w_taken = SC_SEQ_PSR_InBUS[2];
      3'b011:  w_taken = SC_SEQ_PSR_InBUS[1];
      3'b100:  w_taken = SC_SEQ_PSR_InBUS[0];
      3'b101:  w_taken = SC_SEQ_IR_InBUS[13];
      3'b110:  w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_next = (SC_SEQ_Cond_InBUS == 3'b111) ? w_decode :
                  w_taken                       ? SC_SEQ_JumpAddr_InBUS : w_incr;

`ifdef SC_SEQ_WAITSTATE_EN
  // Read and Write together still form a single access.
  assign w_pending = (SC_SEQ_Read_In | SC_SEQ_Write_In) & ~SC_SEQ_MemReady_In;
  assign w_ready   = SC_SEQ_MemReady_In;
  assign w_unused  = ^{SC_SEQ_IR_InBUS[29:25], SC_SEQ_IR_InBUS[18:14], SC_SEQ_IR_InBUS[12:0]};
`else
  assign w_pending = 1'b0;
  assign w_ready   = 1'b1;
  assign w_unused  = ^{SC_SEQ_IR_InBUS[29:25], SC_SEQ_IR_InBUS[18:14], SC_SEQ_IR_InBUS[12:0],
                       SC_SEQ_Read_In, SC_SEQ_Write_In, SC_SEQ_MemReady_In};
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge SC_SEQ_CLOCK_50 or negedge SC_SEQ_RESET_InLow) begin
    if (!SC_SEQ_RESET_InLow) begin
      r_state   <= ST_BOOT;
      r_csaddr  <= SEQ_RESETADDR;
      r_mirload <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_BOOT: begin
          r_state   <= ST_RUN;
          r_mirload <= 1'b0;
          r_stall   <= 1'b0;
        end
        ST_RUN: begin
          if (w_pending) begin
            r_state   <= ST_WAIT;
            r_mirload <= 1'b0;
            r_stall   <= 1'b1;
          end else begin
            r_csaddr  <= w_next;
            r_mirload <= 1'b1;
            r_stall   <= 1'b0;
          end
        end
        ST_WAIT: begin
          // The held microword is still at the inputs, so exit computes its successor.
          if (w_ready) begin
            r_state   <= ST_RUN;
            r_csaddr  <= w_next;
            r_mirload <= 1'b1;
            r_stall   <= 1'b0;
          end else begin
            r_mirload <= 1'b0;
            r_stall   <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_BOOT;
          r_mirload <= 1'b0;
          r_stall   <= 1'b0;
        end
      endcase
    end
  end

  assign SC_SEQ_CSAddr_OutBUS = r_csaddr;
  assign SC_SEQ_MIRLoad_Out   = r_mirload;
  assign SC_SEQ_Stall_Out     = r_stall;

endmodule
